// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WORD_W = 16;

  localparam logic [15:0] DEF_BASE_ADDR = 16'h0000;
  localparam int unsigned DEF_ADDR_STEP = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DAT_HI = 3'd3,
    S_DAT_LO = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  function automatic logic is_byte_state(input state_t s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DAT_HI) || (s == S_DAT_LO);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Saturating idle-cycle counter; o_expired flags TIMEOUT_CYCLES consecutive enabled cycles.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic w_unused;
      assign w_unused  = ^{clk, rst, i_clear, i_enable};
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst || i_clear) begin
          r_cnt <= '0;
        end else if (i_enable && (r_cnt != LIMIT)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign o_expired = (r_cnt == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed big-endian program image into instruction memory,
// holding the processor in reset until the image has been fully written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = ADDR_W'(DEF_BASE_ADDR),
  parameter int unsigned       ADDR_STEP      = DEF_ADDR_STEP,
  parameter int unsigned       MAX_WORDS      = 256,
  parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              im_wr_en,
  output logic [ADDR_W-1:0] im_wr_addr,
  output logic [WORD_W-1:0] im_wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              r_state, w_state_nxt;
  logic [BYTE_W-1:0]   r_len_hi, r_hi;
  logic [LEN_W-1:0]    r_len, r_wcnt;
  logic [WORD_W-1:0]   r_data;
  logic [ADDR_W-1:0]   r_addr;

  logic                w_byte_state, w_xfer, w_to_expired;
  logic [LEN_W-1:0]    w_len, w_wcnt_inc;

  assign w_byte_state = is_byte_state(r_state);
  assign w_xfer       = byte_valid && w_byte_state;
  assign w_len        = {r_len_hi, byte_in};
  assign w_wcnt_inc   = r_wcnt + LEN_W'(1);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_xfer || !w_byte_state),
    .i_enable (w_byte_state && !w_xfer),
    .o_expired(w_to_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_state_nxt = S_LEN_HI;
      end
      S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO: begin
        if (w_xfer) begin
          case (r_state)
            S_LEN_HI: w_state_nxt = S_LEN_LO;
            S_LEN_LO: begin
              if (w_len == '0)                 w_state_nxt = S_DONE;
              else if (32'(w_len) > MAX_WORDS) w_state_nxt = S_ERR;
              else                             w_state_nxt = S_DAT_HI;
            end
            S_DAT_HI: w_state_nxt = S_DAT_LO;
            default:  w_state_nxt = S_WRITE;
          endcase
        end else if (w_to_expired) begin
          w_state_nxt = S_ERR;
        end
      end
      S_WRITE: w_state_nxt = (w_wcnt_inc == r_len) ? S_DONE : S_DAT_HI;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_hold   = 1'b1;
    im_wr_en   = 1'b0;
    case (r_state)
      S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      S_WRITE: begin
        busy     = 1'b1;
        im_wr_en = 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_hi <= '0;
      r_len    <= '0;
      r_hi     <= '0;
      r_data   <= '0;
      r_addr   <= BASE_ADDR;
      r_wcnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_addr <= BASE_ADDR;
            r_wcnt <= '0;
          end
        end
        S_LEN_HI: if (w_xfer) r_len_hi <= byte_in;
        S_LEN_LO: if (w_xfer) r_len <= w_len;
        S_DAT_HI: if (w_xfer) r_hi <= byte_in;
        S_DAT_LO: if (w_xfer) r_data <= {r_hi, byte_in};
        S_WRITE: begin
          r_addr <= r_addr + ADDR_W'(ADDR_STEP);
          r_wcnt <= w_wcnt_inc;
        end
        default: ;
      endcase
    end
  end

  assign im_wr_addr = r_addr;
  assign im_wr_data = r_data;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed images, expected writes queued at issue time.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, im_wr_en, cpu_hold, busy, done, err;
  logic [15:0] im_wr_addr, im_wr_data;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W        (16),
    .BASE_ADDR     (16'h0000),
    .ADDR_STEP     (2),
    .MAX_WORDS     (256),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .im_wr_en  (im_wr_en),
    .im_wr_addr(im_wr_addr),
    .im_wr_data(im_wr_data),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (im_wr_en) begin
      wr_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", im_wr_addr, im_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (im_wr_addr !== e.addr || im_wr_data !== e.data) begin
          bad++;
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   im_wr_addr, im_wr_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g = 0;
    int n = 0;
    byte_valid = 1'b0;
    while (g < max_gap && $urandom_range(0, 1) == 0) begin
      @(negedge clk);
      g++;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL byte_accept_timeout: got byte_ready=0 for 50 cycles, expected 1");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int max_gap);
    send_byte(w[15:8], max_gap);
    send_byte(w[7:0], max_gap);
  endtask

  initial begin
    logic [15:0] w;
    int          n;

    // Reset and idle without start
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", im_wr_addr, 16'h0000);
    chk("rst_data", im_wr_data, 16'h0000);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_cpu_hold", cpu_hold, 1);
      chk("idle_byte_ready", byte_ready, 0);
    end

    // Three-word image
    pulse_start();
    chk("start_busy", busy, 1);
    expect_wr(16'h0000, 16'h1234);
    expect_wr(16'h0002, 16'hABCD);
    expect_wr(16'h0004, 16'h00FF);
    send_word(16'h0003, 0);
    send_word(16'h1234, 0);
    send_word(16'hABCD, 0);
    send_word(16'h00FF, 0);
    chk("t3_last_strobe", im_wr_en, 1);
    chk("t3_hold_during_write", cpu_hold, 1);
    @(negedge clk);
    chk("t3_done", done, 1);
    chk("t3_cpu_hold", cpu_hold, 0);
    chk("t3_busy", busy, 0);
    chk("t3_queue_empty", exp_q.size(), 0);

    // Zero length goes straight to DONE
    pulse_start();
    chk("restart_clears_done", done, 0);
    send_word(16'h0000, 0);
    chk("len0_done", done, 1);
    chk("len0_cpu_hold", cpu_hold, 0);
    chk("len0_err", err, 0);

    // Length above MAX_WORDS aborts
    pulse_start();
    send_word(16'h0101, 0);
    chk("len_big_err", err, 1);
    chk("len_big_done", done, 0);
    chk("len_big_cpu_hold", cpu_hold, 1);

    // Stall after a partial word until timeout
    pulse_start();
    chk("restart_clears_err", err, 0);
    send_word(16'h0002, 0);
    send_byte(8'h12, 0);
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, 17);
    chk("timeout_err", err, 1);
    chk("timeout_cpu_hold", cpu_hold, 1);

    pulse_start();
    expect_wr(16'h0000, 16'hBEEF);
    send_word(16'h0001, 0);
    send_word(16'hBEEF, 0);
    @(negedge clk);
    chk("after_timeout_done", done, 1);

    // 64-word image with irregular byte_valid
    pulse_start();
    send_word(16'h0040, 3);
    for (int i = 0; i < 64; i++) begin
      w = 16'(i * 16'h1357) ^ 16'hA5C3;
      expect_wr(16'(i * 2), w);
      send_word(w, 6);
    end
    @(negedge clk);
    chk("burst_done", done, 1);
    chk("burst_queue_empty", exp_q.size(), 0);

    // Reset on the second write of four
    pulse_start();
    expect_wr(16'h0000, 16'h1111);
    expect_wr(16'h0002, 16'h2222);
    send_word(16'h0004, 0);
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    chk("mid_rst_strobe", im_wr_en, 1);
    chk("mid_rst_strobe_addr", im_wr_addr, 16'h0002);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_wr_en", im_wr_en, 0);
    chk("mid_rst_cpu_hold", cpu_hold, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_byte_ready", byte_ready, 0);
    chk("mid_rst_addr", im_wr_addr, 16'h0000);

    pulse_start();
    expect_wr(16'h0000, 16'hCAFE);
    send_word(16'h0001, 0);
    send_word(16'hCAFE, 0);
    @(negedge clk);
    chk("after_rst_done", done, 1);
    repeat (5) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
